// File: rtl/uart_ram_loader.sv
// UART program loader: 8N1 receiver feeding a header/length/payload FSM
// that writes into block RAM. Define LOADER_CHECKSUM_EN for a trailing sum byte.
module uart_ram_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TIMEOUT_CLKS = 5000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_write_en,
  output logic       cpu_hold,
  output logic       done,
  output logic       err,
  output logic [7:0] byte_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, FINISH, ABORT
`ifdef LOADER_CHECKSUM_EN
    , CSUM
`endif
  } ld_state_t;

  logic          rx_meta, rx_s, rx_prev;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          byte_valid, frame_err;

  // Sync flops reset to idle-high so reset never looks like a start edge
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s && rx_prev) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  ld_state_t     state, state_n;
  logic [8:0]    remain;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, in_load;
  logic          hdr, len_ld, wr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`ifdef LOADER_CHECKSUM_EN
  assign in_load = (state == LEN) || (state == DATA) || (state == CSUM);
`else
  assign in_load = (state == LEN) || (state == DATA);
`endif

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A byte always takes priority over a same-cycle timeout
  always_comb begin
    state_n = state;
    hdr     = 1'b0;
    len_ld  = 1'b0;
    wr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (byte_valid && rx_byte_is_sync()) begin
          hdr     = 1'b1;
          state_n = LEN;
        end
      end
      LEN: begin
        if (byte_valid) begin
          len_ld  = 1'b1;
          state_n = DATA;
        end else if (frame_err || tmo_hit) begin
          state_n = ABORT;
        end
      end
      DATA: begin
        if (byte_valid) begin
          wr = 1'b1;
          if (remain == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = CSUM;
`else
            state_n = FINISH;
`endif
          end
        end else if (frame_err || tmo_hit) begin
          state_n = ABORT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (byte_valid) begin
          state_n = (rx_shift == sum) ? FINISH : ABORT;
        end else if (frame_err || tmo_hit) begin
          state_n = ABORT;
        end
      end
`endif
      FINISH:  state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  function automatic logic rx_byte_is_sync();
    return rx_shift == SYNC_BYTE;
  endfunction

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      ram_addr     <= '0;
      ram_data     <= '0;
      ram_write_en <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      byte_count   <= '0;
      remain       <= '0;
      tmo_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      ram_write_en <= wr;
      if (ram_write_en) ram_addr <= ram_addr + 8'd1;
      if (hdr) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        byte_count <= '0;
        ram_addr   <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end
      if (len_ld) remain <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
      if (wr) begin
        ram_data <= rx_shift;
        remain   <= remain - 9'd1;
        if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
`ifdef LOADER_CHECKSUM_EN
        sum      <= sum + rx_shift;
`endif
      end
      if (state == FINISH) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (state == ABORT) begin
        err      <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (byte_valid || !in_load) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: vector table plus multi-cycle
// sequences (256-byte load, timeout, async reset mid-frame).
module tb_uart_ram_loader;

  localparam int CPB = 16;
  localparam int TMO = 2000;

  logic       qzt_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic [7:0] ram_addr, ram_data, byte_count;
  logic       ram_write_en, cpu_hold, done, err;

  always #5 qzt_clk = ~qzt_clk;

  uart_ram_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .SYNC_BYTE(8'h55)
  ) dut (
    .qzt_clk(qzt_clk),
    .reset(reset),
    .rx(rx),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_write_en(ram_write_en),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err),
    .byte_count(byte_count)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];

  always @(negedge qzt_clk)
    if (ram_write_en) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
    end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {21'd0, cpu_hold, done, err, byte_count};
  endfunction

  function automatic logic [31:0] ex(input logic h, input logic d,
                                     input logic e, input logic [7:0] c);
    return {21'd0, h, d, e, c};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge qzt_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge qzt_clk);
    end
    rx = stop;
    repeat (CPB) @(negedge qzt_clk);
    rx = 1'b1;
    repeat (CPB) @(negedge qzt_clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       hold;
    logic       dn;
    logic       er;
    logic [7:0] cnt;
    int         nwr;
    string      name;
  } vec_t;

  vec_t vq[$];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;

    vq.push_back('{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, "idle_stray"});
    vq.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, "idle_badframe"});
    vq.push_back('{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 0, "hdr"});
    vq.push_back('{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 0, "len3"});
    vq.push_back('{8'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1, "d0"});
    vq.push_back('{8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 2, "d1"});
`ifdef LOADER_CHECKSUM_EN
    vq.push_back('{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 3, "d2"});
    vq.push_back('{8'h16, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 3, "csum_ok"});
`else
    vq.push_back('{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 3, "d2_done"});
`endif
    vq.push_back('{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3, "hdr2"});
    vq.push_back('{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3, "len2"});
    vq.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3, "data_badframe"});
    vq.push_back('{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 3, "idle_stray2"});

    repeat (4) @(negedge qzt_clk);
    chk("reset_state",
        {4'd0, ram_addr, ram_data, ram_write_en, cpu_hold, done, err,
         byte_count}, 32'd0);
    reset = 1'b0;
    repeat (CPB * 2) @(negedge qzt_clk);

    foreach (vq[k]) begin
      send_frame(vq[k].data, vq[k].stop);
      chk(vq[k].name, st(), ex(vq[k].hold, vq[k].dn, vq[k].er, vq[k].cnt));
      chk({vq[k].name, "_wr"}, 32'(wa.size()), 32'(vq[k].nwr));
    end
    if (wa.size() >= 3) begin
      chk("load3_addr", {8'd0, wa[0], wa[1], wa[2]}, 32'h0000_0102);
      chk("load3_data", {8'd0, wd[0], wd[1], wd[2]}, 32'h00A1_B2C3);
    end else begin
      chk("load3_present", 32'(wa.size()), 32'd3);
    end

`ifdef LOADER_CHECKSUM_EN
    base = wa.size();
    send(8'h55); send(8'h02); send(8'h10); send(8'h20); send(8'h30);
    chk("csum_good", st(), ex(1'b0, 1'b1, 1'b0, 8'd2));
    chk("csum_good_wr", 32'(wa.size()), 32'(base + 2));
    send(8'h55); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    chk("csum_bad", st(), ex(1'b0, 1'b0, 1'b1, 8'd2));
    chk("csum_bad_wr", 32'(wa.size()), 32'(base + 4));
`endif

    base = wa.size();
    send(8'h55);
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send(8'h80);
`endif
    chk("n256_state", st(), ex(1'b0, 1'b1, 1'b0, 8'hFF));
    chk("n256_wr", 32'(wa.size()), 32'(base + 256));
    chk("n256_addr_wrap", {24'd0, ram_addr}, 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (base + i >= wa.size() ||
          wa[base + i] != 8'(i) || wd[base + i] != 8'(i)) bad++;
    chk("n256_contents", 32'(bad), 32'd0);
    if (wa.size() > 0)
      chk("n256_last", {16'd0, wa[$], wd[$]}, 32'h0000_FFFF);
    send(8'h77);
    chk("n256_no_extra", 32'(wa.size()), 32'(base + 256));

    base = wa.size();
    send(8'h55); send(8'h04); send(8'h11); send(8'h22);
    repeat (1900) @(negedge qzt_clk);
    chk("tmo_before", st(), ex(1'b1, 1'b0, 1'b0, 8'd2));
    repeat (200) @(negedge qzt_clk);
    chk("tmo_after", st(), ex(1'b0, 1'b0, 1'b1, 8'd2));
    chk("tmo_wr", 32'(wa.size()), 32'(base + 2));

    base = wa.size();
    send(8'h55); send(8'h05); send(8'h01);
    fork
      send(8'h02);
      begin
        repeat (CPB * 4 + CPB / 2) @(negedge qzt_clk);
        #2 reset = 1'b1;
        #1 chk("rst_async",
               {4'd0, ram_addr, ram_data, ram_write_en, cpu_hold, done, err,
                byte_count}, 32'd0);
        repeat (5) @(negedge qzt_clk);
        reset = 1'b0;
      end
    join
    repeat (CPB * 14) @(negedge qzt_clk);
    chk("rst_wr", 32'(wa.size()), 32'(base + 1));
    chk("rst_idle", st(), ex(1'b0, 1'b0, 1'b0, 8'd0));
    send(8'h55); send(8'h01); send(8'hEE);
`ifdef LOADER_CHECKSUM_EN
    send(8'hEE);
`endif
    chk("post_rst_state", st(), ex(1'b0, 1'b1, 1'b0, 8'd1));
    chk("post_rst_wr", 32'(wa.size()), 32'(base + 2));
    if (wa.size() > 0)
      chk("post_rst_last", {16'd0, wa[$], wd[$]}, 32'h0000_00EE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
